// File: rtl/pkt_parser_pkg.sv
// Shared types and defaults for the parametrised packet parser.
// No logic; imported by the parser top and available to sub-blocks.
// Contents: FSM state enum, default header word counts, counter width helper.
package pkt_parser_pkg;

  typedef enum logic [2:0] {
    S_ETH  = 3'd0,
    S_IP   = 3'd1,
    S_TCP  = 3'd2,
    S_PAY  = 3'd3,
    S_DROP = 3'd4
  } state_t;

  localparam int ETH_WORDS_DEF     = 4;
  localparam int IP_WORDS_DEF      = 5;
  localparam int TCP_WORDS_DEF     = 5;
  localparam int MAX_PAY_WORDS_DEF = 10;

  // The word counter only ever holds 0 .. (largest count - 1).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with registered occupancy flags.
// Latency: a write into an empty FIFO shows on rd_data the next cycle.
// Backpressure: writes while full and reads while empty are ignored.
// Ports: clk, rst (async active-low), wr_en/wr_data, rd_en/rd_data (head),
//        empty, full, count (registered, updated on the write/read edge).
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Head is forced to zero when empty so the output is defined out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10: begin
          count <= count + 1'b1;
          empty <= 1'b0;
          full  <= (count == CW'(DEPTH - 1));
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pkt_parser_fifo_v2.sv
// Eth/IP/TCP header parser that captures headers and buffers payload in a FWFT FIFO.
// Latency: headers publish with hdr_valid 1 cycle after the last TCP word; payload 1 cycle to data_out.
// Backpressure: parser_ready_in drops only in payload state while the FIFO is full.
// Ports: clk, rst (async active-low); data_in/parser_valid_in/parser_last_in/parser_ready_in
//        input stream; eth_hdr/ip_hdr/tcp_hdr + hdr_valid; err_runt/err_long pulses;
//        data_out/data_out_last head of FIFO, fifo_rd_en pop, fifo_* status.
module pkt_parser_fifo_v2
  import pkt_parser_pkg::*;
#(
  parameter int DW            = 32,
  parameter int ETH_WORDS     = ETH_WORDS_DEF,
  parameter int IP_WORDS      = IP_WORDS_DEF,
  parameter int TCP_WORDS     = TCP_WORDS_DEF,
  parameter int MAX_PAY_WORDS = MAX_PAY_WORDS_DEF,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DW-1:0]                   data_in,
  input  logic                            parser_valid_in,
  input  logic                            parser_last_in,
  output logic                            parser_ready_in,
  output logic [DW*ETH_WORDS-1:0]         eth_hdr,
  output logic [DW*IP_WORDS-1:0]          ip_hdr,
  output logic [DW*TCP_WORDS-1:0]         tcp_hdr,
  output logic                            hdr_valid,
  output logic                            err_runt,
  output logic                            err_long,
  output logic [DW-1:0]                   data_out,
  output logic                            data_out_last,
  input  logic                            fifo_rd_en,
  output logic                            fifo_empty_flag,
  output logic                            fifo_full_flag,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

  localparam int CW = cnt_width(ETH_WORDS, IP_WORDS, TCP_WORDS, MAX_PAY_WORDS);
  localparam int EB = DW * ETH_WORDS;
  localparam int IB = DW * IP_WORDS;
  localparam int TB = DW * TCP_WORDS;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [EB-1:0] eth_w;
  logic [IB-1:0] ip_w;
  logic [TB-1:0] tcp_w;
  logic          accept;
  logic          pay_end;
  logic          fifo_wr;
  logic [DW:0]   fifo_wr_data;
  logic [DW:0]   fifo_rd_data;

  assign parser_ready_in = rst && ((state != S_PAY) || !fifo_full_flag);
  assign accept          = parser_valid_in && parser_ready_in;
  assign pay_end         = (cnt == CW'(MAX_PAY_WORDS - 1));
  assign fifo_wr         = accept && (state == S_PAY);
  // The last word allowed into the FIFO is marked last even if the source
  // did not mark it, so the consumer always sees a terminated packet.
  assign fifo_wr_data    = {parser_last_in | pay_end, data_in};

  assign data_out      = fifo_rd_data[DW-1:0];
  assign data_out_last = fifo_rd_data[DW];

  // Header words shift in at the bottom; after a full header the first word
  // sits in the top DW bits. Truncating casts drop the oldest word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_ETH;
      cnt       <= '0;
      eth_w     <= '0;
      ip_w      <= '0;
      tcp_w     <= '0;
      eth_hdr   <= '0;
      ip_hdr    <= '0;
      tcp_hdr   <= '0;
      hdr_valid <= 1'b0;
      err_runt  <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      hdr_valid <= 1'b0;
      err_runt  <= 1'b0;
      err_long  <= 1'b0;
      if (accept) begin
        case (state)
          S_ETH: begin
            eth_w <= EB'({eth_w, data_in});
            if (parser_last_in) begin
              err_runt <= 1'b1;
              cnt      <= '0;
            end else if (cnt == CW'(ETH_WORDS - 1)) begin
              state <= S_IP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_IP: begin
            ip_w <= IB'({ip_w, data_in});
            if (parser_last_in) begin
              err_runt <= 1'b1;
              state    <= S_ETH;
              cnt      <= '0;
            end else if (cnt == CW'(IP_WORDS - 1)) begin
              state <= S_TCP;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_TCP: begin
            tcp_w <= TB'({tcp_w, data_in});
            if (cnt == CW'(TCP_WORDS - 1)) begin
              // Last on the final header word is a valid zero-payload packet.
              eth_hdr   <= eth_w;
              ip_hdr    <= ip_w;
              tcp_hdr   <= TB'({tcp_w, data_in});
              hdr_valid <= 1'b1;
              state     <= parser_last_in ? S_ETH : S_PAY;
              cnt       <= '0;
            end else if (parser_last_in) begin
              err_runt <= 1'b1;
              state    <= S_ETH;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_PAY: begin
            if (parser_last_in) begin
              state <= S_ETH;
              cnt   <= '0;
            end else if (pay_end) begin
              err_long <= 1'b1;
              state    <= S_DROP;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_DROP: begin
            if (parser_last_in) state <= S_ETH;
          end
          default: begin
            state <= S_ETH;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty_flag),
    .full    (fifo_full_flag),
    .count   (fifo_count)
  );

endmodule
